// File: rtl/stereolbm_subpix_div.sv
// stereolbm_subpix_div
// Sequential signed divider for the sub-pixel disparity correction. Takes the
// signed product from the upstream multiplier as numerator and the cost-curve
// curvature term as denominator, and produces a quotient that is truncated
// toward zero and saturated to QUO_WIDTH bits. Radix-2 restoring iteration,
// one quotient bit per enabled cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ce                  clock enable; 0 freezes all state and outputs
//   in_valid/in_ready   operand handshake (in_ready = idle)
//   num, den            signed numerator / denominator
//   out_valid/out_ready result handshake
//   quo                 signed quotient, truncated, saturated
//   sat                 quotient clamped, or denominator zero
//   div0                denominator zero
module stereolbm_subpix_div #(
  parameter int NUM_WIDTH = 52,
  parameter int DEN_WIDTH = 32,
  parameter int QUO_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QUO_WIDTH-1:0] quo,
  output logic                 sat,
  output logic                 div0
);

  localparam int CW = $clog2(NUM_WIDTH);

  // Magnitude limits of the output, expressed at numerator width so they can
  // be compared directly against the full-width quotient magnitude.
  localparam logic [NUM_WIDTH-1:0] QMAX_W   = NUM_WIDTH'(2**(QUO_WIDTH-1) - 1);
  localparam logic [NUM_WIDTH-1:0] QMINMAG_W = NUM_WIDTH'(2**(QUO_WIDTH-1));
  localparam logic [QUO_WIDTH-1:0] QMAX = {1'b0, {(QUO_WIDTH-1){1'b1}}};
  localparam logic [QUO_WIDTH-1:0] QMIN = {1'b1, {(QUO_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  // nq starts as |num|; each step shifts the numerator MSB out and a quotient
  // bit in at the LSB, so after NUM_WIDTH steps it holds |q|.
  logic [NUM_WIDTH-1:0] nq;
  logic [DEN_WIDTH-1:0] dmag;
  logic [DEN_WIDTH:0]   rem;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic                 zflag;

  logic [DEN_WIDTH:0]   sh;
  logic                 ge;
  logic [QUO_WIDTH-1:0] qlo;
  logic [QUO_WIDTH-1:0] qneg;
  logic                 ovf_pos;
  logic                 ovf_neg;

  assign in_ready = (state == IDLE);

  // Extra remainder bit keeps the shifted partial remainder from wrapping
  // before the compare, even for |den| = 2^(DEN_WIDTH-1).
  assign sh      = {rem[DEN_WIDTH-1:0], nq[NUM_WIDTH-1]};
  assign ge      = (sh >= {1'b0, dmag});
  assign qlo     = nq[QUO_WIDTH-1:0];
  assign qneg    = ~qlo + QUO_WIDTH'(1);
  assign ovf_pos = (nq > QMAX_W);
  assign ovf_neg = (nq > QMINMAG_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quo       <= '0;
      sat       <= 1'b0;
      div0      <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Unsigned magnitudes so the most negative operands are exact.
            nq    <= num[NUM_WIDTH-1] ? (~num + NUM_WIDTH'(1)) : num;
            dmag  <= den[DEN_WIDTH-1] ? (~den + DEN_WIDTH'(1)) : den;
            sign  <= num[NUM_WIDTH-1] ^ den[DEN_WIDTH-1];
            zflag <= (den == '0);
            rem   <= '0;
            cnt   <= CW'(NUM_WIDTH - 1);
            state <= CALC;
          end
        end
        CALC: begin
          nq  <= {nq[NUM_WIDTH-2:0], ge};
          rem <= ge ? (sh - {1'b0, dmag}) : sh;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (zflag) begin
            quo  <= sign ? QMIN : QMAX;
            sat  <= 1'b1;
            div0 <= 1'b1;
          end else if (!sign && ovf_pos) begin
            quo  <= QMAX;
            sat  <= 1'b1;
            div0 <= 1'b0;
          end else if (sign && ovf_neg) begin
            quo  <= QMIN;
            sat  <= 1'b1;
            div0 <= 1'b0;
          end else begin
            // Negating a zero magnitude yields zero, so -0 needs no special case.
            quo  <= sign ? qneg : qlo;
            sat  <= 1'b0;
            div0 <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stereolbm_subpix_div.sv
module tb_stereolbm_subpix_div;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, in_ready, out_valid, out_ready;
  logic [51:0] num;
  logic [31:0] den;
  logic [15:0] quo;
  logic        sat, div0;

  int checks = 0;
  int failures = 0;

  stereolbm_subpix_div dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .sat(sat), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [51:0] n;
    logic [31:0] d;
    logic [15:0] q;
    logic        s;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact signed division, truncation toward zero, then clamp.
  task automatic model(input logic [51:0] n, input logic [31:0] d,
                       output logic [15:0] q, output logic s, output logic z);
    longint nn, dd, qq;
    nn = {{12{n[51]}}, n};
    dd = {{32{d[31]}}, d};
    if (dd == 0) begin
      z = 1'b1; s = 1'b1;
      q = (nn < 0) ? 16'h8000 : 16'h7fff;
    end else begin
      z = 1'b0;
      qq = nn / dd;
      if (qq > 32767)       begin q = 16'h7fff; s = 1'b1; end
      else if (qq < -32768) begin q = 16'h8000; s = 1'b1; end
      else                  begin q = qq[15:0]; s = 1'b0; end
    end
  endtask

  // Accepts one operand pair and waits for out_valid. lat counts edges from
  // the accept edge to the edge after which out_valid is first seen. An
  // optional ce pause drops ce for pause_len edges starting after edge pause_at.
  task automatic start_op(input logic [51:0] n, input logic [31:0] d,
                          input int pause_at, input int pause_len,
                          output int lat, output logic [15:0] q,
                          output logic s, output logic z);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    num = n; den = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    num = $urandom; den = $urandom;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (lat == pause_at) ce = 1'b0;
      if (lat == pause_at + pause_len) ce = 1'b1;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    q = quo; s = sat; z = div0;
  endtask

  // Completes the output handshake (out_ready assumed 1) and checks release.
  task automatic finish_op(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_ov_clear"}, out_valid, 0);
    chk({nm, "_ready_back"}, in_ready, 1);
  endtask

  vec_t        tbl[12];
  int          lat;
  logic [15:0] q, mq, hq;
  logic        s, z, ms, mz;
  logic [51:0] rn;
  logic [31:0] rd;

  initial begin
    tbl[0]  = '{52'd100, 32'd7, 16'd14, 1'b0, 1'b0};
    tbl[1]  = '{-52'sd100, 32'd7, -16'sd14, 1'b0, 1'b0};
    tbl[2]  = '{52'd100, -32'sd7, -16'sd14, 1'b0, 1'b0};
    tbl[3]  = '{-52'sd6, -32'sd7, 16'd0, 1'b0, 1'b0};
    tbl[4]  = '{52'd1 << 40, 32'd1, 16'd32767, 1'b1, 1'b0};
    tbl[5]  = '{52'h8_0000_0000_0000, 32'd1, 16'h8000, 1'b1, 1'b0};
    tbl[6]  = '{-52'sd32768, 32'd1, 16'h8000, 1'b0, 1'b0};
    tbl[7]  = '{52'd5, 32'd0, 16'd32767, 1'b1, 1'b1};
    tbl[8]  = '{-52'sd5, 32'd0, 16'h8000, 1'b1, 1'b1};
    tbl[9]  = '{52'h8_0000_0000_0000, 32'h8000_0000, 16'd32767, 1'b1, 1'b0};
    tbl[10] = '{52'd32767, 32'd1, 16'd32767, 1'b0, 1'b0};
    tbl[11] = '{-52'sd32769, 32'd1, 16'h8000, 1'b1, 1'b0};

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    num = '0; den = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quo", quo, 0);
    chk("rst_sat", sat, 0);
    chk("rst_div0", div0, 0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].n, tbl[i].d, -1, 0, lat, q, s, z);
      chk($sformatf("tbl%0d_lat", i), lat, 53);
      chk($sformatf("tbl%0d_quo", i), longint'($signed(q)), longint'($signed(tbl[i].q)));
      chk($sformatf("tbl%0d_sat", i), s, tbl[i].s);
      chk($sformatf("tbl%0d_div0", i), z, tbl[i].z);
      finish_op($sformatf("tbl%0d", i));
    end

    // Backpressure: result and in_ready must hold while out_ready is low
    out_ready = 1'b0;
    start_op(52'd1000, 32'd9, -1, 0, lat, q, s, z);
    chk("bp_quo", q, 16'd111);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_quo_hold", quo, 16'd111);
      chk("bp_in_ready", in_ready, 0);
    end
    finish_op("bp");

    // ce pause mid-CALC extends latency by the pause length
    start_op(52'd100, 32'd7, 10, 5, lat, q, s, z);
    chk("ce_lat", lat, 58);
    chk("ce_quo", q, 16'd14);
    finish_op("ce");

    // Reset 20 cycles into CALC discards the operation
    num = 52'd777; den = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    start_op(52'd9, 32'd3, -1, 0, lat, q, s, z);
    chk("mrst_lat", lat, 53);
    chk("mrst_quo", q, 16'd3);
    chk("mrst_sat", s, 0);
    finish_op("mrst");

    // Randomized operands against the reference model; random right shifts
    // spread magnitudes so both clamped and in-range results occur.
    for (int i = 0; i < 40; i++) begin
      rn = {$urandom, $urandom};
      rn = 52'($signed(rn) >>> $urandom_range(51, 0));
      rd = $urandom;
      rd = 32'($signed(rd) >>> $urandom_range(31, 0));
      if ($urandom_range(15, 0) == 0) rd = '0;
      model(rn, rd, mq, ms, mz);
      start_op(rn, rd, -1, 0, lat, q, s, z);
      hq = q;
      chk($sformatf("rnd%0d_quo", i), longint'($signed(hq)), longint'($signed(mq)));
      chk($sformatf("rnd%0d_sat", i), s, ms);
      chk($sformatf("rnd%0d_div0", i), z, mz);
      finish_op($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
